uart_rx_deserializer: RTL and testbench

- UART receiver feeding the debug unit's command/data byte interface (rx_data / rx_done) of the MIPS pipeline top.
- Synchronises the serial RX pin, detects and validates the start bit, and samples 8N1 frames with 16x oversampling.
- Delivers each byte with a one-cycle done pulse; flags framing errors.
- Contains its own free-running baud tick generator.

---
 rtl/uart_rx_deserializer_pkg.sv | 23 ++
 rtl/uart_rx_deserializer_baud_tick_gen.sv | 28 ++
 rtl/uart_rx_deserializer.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_deserializer_pkg.sv
// Shared UART definitions: receiver FSM state encodings and oversampling
// constants. The transmit side reuses the same package.
package uart_rx_deserializer_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

    // Oversample ticks per bit period
    localparam int UART_OVERSAMPLE = 16;

    // Sample index at the middle of the start bit
    localparam int S_MID_START = 7;

    // Sample index that closes a full bit period
    localparam int S_END_BIT = 15;

endpackage

// File: rtl/uart_rx_deserializer_baud_tick_gen.sv
// Free-running oversample tick generator: one-cycle o_tick every TICK_DIV clocks.
module baud_tick_gen #(
    parameter int TICK_DIV    = 326,
    parameter int NB_TICK_CNT = 9
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_tick
);

    logic [NB_TICK_CNT-1:0] r_cnt;
    logic                   w_tick;

    assign w_tick = (r_cnt == NB_TICK_CNT'(TICK_DIV - 1));
    assign o_tick = w_tick;

    // Divider counter: wraps to zero on the tick cycle, never stalls
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver with 16x oversampling, start-bit validation and
// framing-error detection.
//
// Output handshake: o_rx_done is a one-cycle valid strobe with no ready;
// o_rx_data is valid in that same cycle and holds until the next good frame.
// o_frame_err is a one-cycle strobe, never coincident with o_rx_done.
module uart_rx_deserializer
    import uart_rx_deserializer_pkg::*;
#(
    parameter int NB_DATA     = 8,
    parameter int TICK_DIV    = 326,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int NB_TICK_CNT = 9
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam int NB_S = $clog2(OVERSAMPLE);
    localparam int NB_N = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    logic               r_rx_meta;
    logic               r_rx_sync;
    logic               w_tick;

    rx_state_e          r_state;
    rx_state_e          w_state_next;
    logic [NB_S-1:0]    r_s;
    logic [NB_S-1:0]    w_s_next;
    logic [NB_N-1:0]    r_n;
    logic [NB_N-1:0]    w_n_next;
    logic [NB_DATA-1:0] r_shift;
    logic [NB_DATA-1:0] w_shift_next;
    logic [NB_DATA-1:0] r_rx_data;
    logic [NB_DATA-1:0] w_rx_data_next;
    logic               r_rx_done;
    logic               w_rx_done_next;
    logic               r_frame_err;
    logic               w_frame_err_next;

    baud_tick_gen #(
        .TICK_DIV    (TICK_DIV),
        .NB_TICK_CNT (NB_TICK_CNT)
    ) u_tick (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .o_tick  (w_tick)
    );

    // Two-flop synchroniser on the asynchronous RX pin, idling high
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // FSM state, counters, shift register and output registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_n         <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_s         <= w_s_next;
            r_n         <= w_n_next;
            r_shift     <= w_shift_next;
            r_rx_data   <= w_rx_data_next;
            r_rx_done   <= w_rx_done_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    // Next-state logic: sample counter advances on ticks only
    always_comb begin
        w_state_next     = r_state;
        w_s_next         = r_s;
        w_n_next         = r_n;
        w_shift_next     = r_shift;
        w_rx_data_next   = r_rx_data;
        w_rx_done_next   = 1'b0;
        w_frame_err_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_sync) begin
                    w_state_next = ST_START;
                    w_s_next     = '0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_s == NB_S'(S_MID_START)) begin
                        // Line still low at mid start bit: a real frame
                        w_s_next = '0;
                        w_n_next = '0;
                        if (!r_rx_sync) begin
                            w_state_next = ST_DATA;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_s == NB_S'(S_END_BIT)) begin
                        // LSB arrives first, so new bits enter at the top
                        w_shift_next = {r_rx_sync, r_shift[NB_DATA-1:1]};
                        w_s_next     = '0;
                        if (r_n == NB_N'(NB_DATA - 1)) begin
                            w_state_next = ST_STOP;
                        end else begin
                            w_n_next = r_n + 1'b1;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_s == NB_S'(S_END_BIT)) begin
                        w_s_next = '0;
                        if (r_rx_sync) begin
                            w_rx_data_next = r_shift;
                            w_rx_done_next = 1'b1;
                            w_state_next   = ST_IDLE;
                        end else begin
                            w_frame_err_next = 1'b1;
                            w_state_next     = ST_WAIT_HIGH;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low line must return high before a new frame
                if (r_rx_sync) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_rx_data   = r_rx_data;
    assign o_rx_done   = r_rx_done;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Testbench for uart_rx_deserializer with a fast divider (1 bit = 64 clocks).
module tb_uart_rx_deserializer;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = TICK_DIV * 16;
  localparam int LAT_MIN  = 604;
  localparam int LAT_MAX  = 616;

  // ---------------- clock / reset ----------------
  logic       i_clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_rx    = 1'b1;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_busy;

  always #5 i_clock = ~i_clock;

  uart_rx_deserializer #(
    .NB_DATA     (8),
    .TICK_DIV    (TICK_DIV),
    .OVERSAMPLE  (16),
    .NB_TICK_CNT (9)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_rx        (i_rx),
    .o_rx_data   (o_rx_data),
    .o_rx_done   (o_rx_done),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  // ---------------- bookkeeping ----------------
  int         checks    = 0;
  int         failures  = 0;
  int         cyc       = 0;
  int         exp_err   = 0;
  int         err_seen  = 0;
  int         done_seen = 0;
  logic [7:0] model_data = 8'h00;
  logic [7:0] exp_q[$];
  int         exp_t_q[$];

  always @(posedge i_clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b);
    i_rx = b;
    repeat (BIT_CLKS) @(negedge i_clock);
  endtask

  task automatic idle_bits(input int n);
    drive_bit(1'b1);
    for (int i = 1; i < n; i++) drive_bit(1'b1);
  endtask

  // A good frame is announced to the scoreboard with its start-edge cycle
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit good);
    if (good) begin
      exp_q.push_back(d);
      exp_t_q.push_back(cyc);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  // ---------------- scoreboard / compare ----------------
  always begin
    int t;
    @(posedge i_clock);
    #1;
    if (!i_reset) begin
      check("reset_rx_data", o_rx_data, 8'h00);
      check("reset_rx_done", o_rx_done, 1'b0);
      check("reset_frame_err", o_frame_err, 1'b0);
      check("reset_busy", o_busy, 1'b0);
      model_data = 8'h00;
    end else begin
      check("done_err_exclusive", o_rx_done & o_frame_err, 1'b0);
      if (o_frame_err) err_seen++;
      if (o_rx_done) begin
        done_seen++;
        check("done_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          model_data = exp_q.pop_front();
          t = exp_t_q.pop_front();
          check("rx_data_on_done", o_rx_data, model_data);
          check("done_latency", ((cyc - t) >= LAT_MIN) && ((cyc - t) <= LAT_MAX), 1'b1);
        end
      end else begin
        check("rx_data_held", o_rx_data, model_data);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    repeat (100000) @(posedge i_clock);
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- directed scenarios ----------------
  initial begin
    // 1: reset held with RX toggling, then release into idle
    i_reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clock);
      i_rx = ~i_rx;
    end
    @(negedge i_clock);
    i_rx = 1'b1;
    i_reset = 1'b1;
    repeat (100) @(negedge i_clock);
    check("s1_busy_idle", o_busy, 1'b0);
    check("s1_no_done", done_seen, 0);
    check("s1_rx_data_zero", o_rx_data, 8'h00);

    // 2: single frame 0x01
    send_frame(8'h01, 1'b1, 1'b1);
    idle_bits(2);
    check("s2_rx_data", o_rx_data, 8'h01);
    check("s2_done_count", done_seen, 1);
    check("s2_busy_idle", o_busy, 1'b0);
    check("s2_no_err", err_seen, 0);

    // 3: back-to-back frames, no idle bits between them
    send_frame(8'hA5, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle_bits(2);
    check("s3_rx_data", o_rx_data, 8'h3C);
    check("s3_done_count", done_seen, 3);

    // 4: 16-clock glitch is rejected at mid start bit
    i_rx = 1'b0;
    repeat (8) @(negedge i_clock);
    check("s4_busy_in_glitch", o_busy, 1'b1);
    repeat (8) @(negedge i_clock);
    i_rx = 1'b1;
    repeat (BIT_CLKS) @(negedge i_clock);
    check("s4_busy_back_idle", o_busy, 1'b0);
    check("s4_done_count", done_seen, 3);
    check("s4_no_err", err_seen, 0);

    // 5: framing error followed by a held-low line, then recovery
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0);
    exp_err++;
    drive_bit(1'b0);
    drive_bit(1'b0);
    check("s5_busy_wait_high", o_busy, 1'b1);
    idle_bits(2);
    check("s5_err_count", err_seen, 1);
    check("s5_rx_data_kept", o_rx_data, 8'h01);
    check("s5_done_count", done_seen, 4);
    check("s5_busy_idle", o_busy, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b1);
    idle_bits(2);
    check("s5_rx_data_next", o_rx_data, 8'h7E);
    check("s5_done_count_next", done_seen, 5);

    // 6: reset asserted during data bit 4 of 0xF0
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    i_rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge i_clock);
    check("s6_busy_mid_frame", o_busy, 1'b1);
    #2;
    i_reset = 1'b0;
    #1;
    check("s6_async_rx_data", o_rx_data, 8'h00);
    check("s6_async_busy", o_busy, 1'b0);
    check("s6_async_done", o_rx_done, 1'b0);
    check("s6_async_err", o_frame_err, 1'b0);
    repeat (10) @(negedge i_clock);
    i_reset = 1'b1;
    idle_bits(2);
    check("s6_no_done_aborted", done_seen, 5);
    send_frame(8'h02, 1'b1, 1'b1);
    idle_bits(2);
    check("s6_rx_data", o_rx_data, 8'h02);
    check("s6_done_count", done_seen, 6);

    // End of run: every announced frame delivered, error count matches
    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_err_count", err_seen, exp_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
